// File: rtl/spiker_streamer.sv
// spiker_streamer: snapshots a spike-register frame on start and streams it as
// BEAT_WIDTH beats, repeated once per timestep, with valid/ready handshaking.
module spiker_streamer #(
    parameter int WIDTH      = 32,
    parameter int N_REG      = 24,
    parameter int BEAT_WIDTH = 64,
    parameter int STEP_W     = 8,
    localparam int DATA_WIDTH = N_REG * WIDTH,
    localparam int N_BEATS    = DATA_WIDTH / BEAT_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [STEP_W-1:0]     n_steps_i,
    input  logic [DATA_WIDTH-1:0] regs_i,
    output logic                  busy_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [BEAT_WIDTH-1:0] m_data_o,
    output logic                  m_last_o,
    output logic [STEP_W-1:0]     m_step_o,
    output logic                  done_o
);
    localparam int BW = N_BEATS > 1 ? $clog2(N_BEATS) : 1;

    if (DATA_WIDTH % BEAT_WIDTH != 0) begin : g_bad_width
        $error("DATA_WIDTH must be a multiple of BEAT_WIDTH");
    end

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] frame_q, frame_d;
    logic [STEP_W-1:0]     nsteps_q, nsteps_d;
    logic [STEP_W-1:0]     step_q, step_d;
    logic [BW-1:0]         beat_q, beat_d;
    logic                  streaming, xfer, last_beat, last_step;

    assign streaming = state_q == STREAM;
    assign xfer      = streaming && m_ready_i;
    assign last_beat = beat_q == BW'(N_BEATS - 1);
    assign last_step = step_q == nsteps_q - 1'b1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            frame_q  <= '0;
            nsteps_q <= '0;
            step_q   <= '0;
            beat_q   <= '0;
        end else begin
            frame_q  <= frame_d;
            nsteps_q <= nsteps_d;
            step_q   <= step_d;
            beat_q   <= beat_d;
        end
    end

    // Abort outranks end-of-run, so a transfer in the abort cycle never yields done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = (n_steps_i != '0) ? STREAM : DONE;
            STREAM:  if (abort_i) state_d = IDLE;
                     else if (xfer && last_beat && last_step) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        frame_d  = frame_q;
        nsteps_d = nsteps_q;
        step_d   = step_q;
        beat_d   = beat_q;
        if (state_q == IDLE && start_i) begin
            frame_d  = regs_i;
            nsteps_d = n_steps_i;
            step_d   = '0;
            beat_d   = '0;
        end else if (xfer) begin
            beat_d = last_beat ? '0 : beat_q + 1'b1;
            step_d = last_beat ? step_q + 1'b1 : step_q;
        end
    end

    always_comb begin
        busy_o    = streaming;
        m_valid_o = streaming;
        m_last_o  = streaming && last_beat;
        m_data_o  = streaming ? frame_q[beat_q*BEAT_WIDTH +: BEAT_WIDTH] : '0;
        m_step_o  = streaming ? step_q : '0;
        done_o    = state_q == DONE;
    end
endmodule

// File: tb/tb_spiker_streamer.sv
// tb_spiker_streamer: directed + randomized checks of spiker_streamer against a
// frame-snapshot model (beat b = words 2b+1:2b, repeated per timestep).
module tb_spiker_streamer;
    localparam int WIDTH      = 32;
    localparam int N_REG      = 24;
    localparam int BEAT_WIDTH = 64;
    localparam int STEP_W     = 8;
    localparam int NB         = N_REG * WIDTH / BEAT_WIDTH;

    logic                     clk = 1'b0;
    logic                     rst_i = 1'b0;
    logic                     start_i = 1'b0;
    logic                     abort_i = 1'b0;
    logic                     m_ready_i = 1'b0;
    logic [STEP_W-1:0]        n_steps_i = '0;
    logic [N_REG*WIDTH-1:0]   regs_i = '0;
    logic                     busy_o, m_valid_o, m_last_o, done_o;
    logic [BEAT_WIDTH-1:0]    m_data_o;
    logic [STEP_W-1:0]        m_step_o;

    logic [WIDTH-1:0] snap [N_REG];
    int nlat;
    int errors = 0;
    int checks = 0;

    spiker_streamer #(.WIDTH(WIDTH), .N_REG(N_REG), .BEAT_WIDTH(BEAT_WIDTH), .STEP_W(STEP_W)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
        .n_steps_i(n_steps_i), .regs_i(regs_i), .busy_o(busy_o), .m_valid_o(m_valid_o),
        .m_ready_i(m_ready_i), .m_data_o(m_data_o), .m_last_o(m_last_o),
        .m_step_o(m_step_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic exp_done);
        chk({tag, "_valid"}, m_valid_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_last"}, m_last_o, 0);
        chk({tag, "_data"}, m_data_o, 0);
        chk({tag, "_done"}, done_o, exp_done);
    endtask

    task automatic arm(input int n, input bit seq);
        for (int i = 0; i < N_REG; i++) begin
            snap[i] = seq ? WIDTH'(i + 1) : WIDTH'($urandom);
            regs_i[i*WIDTH +: WIDTH] = snap[i];
        end
        n_steps_i = STEP_W'(n);
        nlat = n;
        start_i = 1'b1;
    endtask

    // Scramble the inputs right after the start edge; the stream must not notice.
    task automatic fire;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        regs_i = '1;
        n_steps_i = STEP_W'($urandom_range(1, 255));
    endtask

    task automatic stream(input int mode, input int stop_at);
        int k = 0;
        int cyc = 0;
        int total = nlat * NB;
        while (k < total && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            chk("valid", m_valid_o, 1);
            chk("busy", busy_o, 1);
            chk("done_mid", done_o, 0);
            chk("data", m_data_o, {snap[2*(k%NB)+1], snap[2*(k%NB)]});
            chk("last", m_last_o, (k % NB) == NB - 1);
            chk("step", m_step_o, k / NB);
            if (k == stop_at) begin
                start_i = 1'b0;
                return;
            end
            m_ready_i = mode == 0 ? 1'b1 : mode == 1 ? cyc[0] : 1'($urandom);
            start_i = 1'($urandom);
            n_steps_i = STEP_W'($urandom);
            @(posedge clk);
            if (m_ready_i) k++;
        end
        chk("beats_sent", k, total);
        if (mode == 0) chk("throughput_cycles", cyc, total);
    endtask

    task automatic finish_run;
        @(negedge clk);
        chk_idle("done_cycle", 1'b1);
        start_i = 1'b1;
        abort_i = 1'b1;
        n_steps_i = 8'd5;
        @(negedge clk);
        chk_idle("after_done", 1'b0);
        start_i = 1'b0;
        abort_i = 1'b0;
    endtask

    initial begin
        #1 rst_i = 1'b1;
        #1 chk_idle("reset", 1'b0);
        chk("reset_step", m_step_o, 0);
        @(negedge clk);
        rst_i = 1'b0;

        arm(1, 1'b1);
        fire();
        stream(0, -1);
        finish_run();

        arm(3, 1'b0);
        fire();
        stream(1, -1);
        finish_run();

        arm(2, 1'b0);
        fire();
        stream(0, 5);
        abort_i = 1'b1;
        m_ready_i = 1'($urandom);
        @(posedge clk);
        #1 abort_i = 1'b0;
        @(negedge clk);
        chk_idle("after_abort", 1'b0);
        @(negedge clk);
        chk_idle("after_abort2", 1'b0);
        arm(1, 1'b0);
        fire();
        stream(2, -1);
        finish_run();

        arm(0, 1'b0);
        fire();
        @(negedge clk);
        chk_idle("zero_steps", 1'b1);
        @(negedge clk);
        chk_idle("zero_steps_after", 1'b0);
        @(negedge clk);
        chk_idle("zero_steps_after2", 1'b0);

        arm(2, 1'b0);
        fire();
        stream(0, 7);
        #2 rst_i = 1'b1;
        #1 chk_idle("async_reset", 1'b0);
        chk("async_reset_step", m_step_o, 0);
        #1 rst_i = 1'b0;
        arm(1, 1'b0);
        fire();
        stream(0, -1);
        finish_run();

        for (int r = 0; r < 5; r++) begin
            arm($urandom_range(1, 4), 1'b0);
            fire();
            stream(2, -1);
            finish_run();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spiker_streamer.md
SPIKER_STREAMER -- requirements
Module: spiker_streamer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, bits per spike register word.
REQ-002 SHALL have parameter N_REG, default 24, number of spike register words.
REQ-003 SHALL have parameter BEAT_WIDTH, default 64, output beat width in bits.
REQ-004 SHALL have parameter STEP_W, default 8, width of the timestep count.
REQ-005 SHALL derive DATA_WIDTH = N_REG*WIDTH and N_BEATS = DATA_WIDTH/BEAT_WIDTH, and fail elaboration if DATA_WIDTH mod BEAT_WIDTH != 0.
REQ-006 SHALL have one clock and an asynchronous, active-high reset.
REQ-007 clk_i  input  1  clock; all state changes on rising edge.
REQ-008 rst_i  input  1  asynchronous, active-high reset.
REQ-009 start_i  input  1  start a streaming run (single-cycle pulse or level).
REQ-010 abort_i  input  1  terminate the current run.
REQ-011 n_steps_i  input  STEP_W  number of timesteps (frame repetitions) per run.
REQ-012 regs_i  input  DATA_WIDTH  flattened spike registers; word i at bits [(i+1)*WIDTH-1 : i*WIDTH].
REQ-013 busy_o  output  1  run in progress (STREAM state).
REQ-014 m_valid_o  output  1  beat valid.
REQ-015 m_ready_i  input  1  downstream ready.
REQ-016 m_data_o  output  BEAT_WIDTH  current beat.
REQ-017 m_last_o  output  1  current beat is the last beat of its timestep.
REQ-018 m_step_o  output  STEP_W  timestep index of current beat.
REQ-019 done_o  output  1  one-cycle run-complete pulse.

Function
REQ-020 SHALL implement states IDLE, STREAM, DONE.
REQ-021 In IDLE, start_i=1 with n_steps_i!=0 SHALL snapshot regs_i into an internal frame register, latch n_steps_i, clear beat and step counters, and enter STREAM next cycle.
REQ-022 In IDLE, start_i=1 with n_steps_i=0 SHALL enter DONE with no beats emitted.
REQ-023 start_i SHALL be ignored in STREAM and DONE.
REQ-024 In STREAM, m_valid_o=1 and busy_o=1; m_data_o = frame bits [(b+1)*BEAT_WIDTH-1 : b*BEAT_WIDTH] for beat counter b; m_step_o = step counter; m_last_o = (b == N_BEATS-1).
REQ-025 First beat SHALL be valid in cycle T+1 for start in cycle T.
REQ-026 A transfer occurs when m_valid_o and m_ready_i are both 1; m_data_o, m_last_o and m_step_o SHALL hold stable while m_valid_o=1 and m_ready_i=0.
REQ-027 On transfer with b<N_BEATS-1: b increments.
REQ-028 On transfer with b=N_BEATS-1: b wraps to 0; if step = latched n_steps-1, enter DONE; else step increments.
REQ-029 One beat per cycle SHALL be sustained when m_ready_i is held at 1.
REQ-030 Changes on regs_i and n_steps_i after start SHALL NOT affect the running stream.
REQ-031 In DONE, done_o=1 and busy_o=0 for exactly one cycle, then IDLE.
REQ-032 abort_i=1 in STREAM SHALL enter IDLE next cycle, m_valid_o=0, no done_o pulse; a beat transferred in the abort cycle counts as consumed; abort has priority over end-of-run.
REQ-033 abort_i SHALL be ignored in IDLE and DONE.
REQ-034 Outside STREAM, m_valid_o=0, m_last_o=0 and m_data_o=0.

Reset
REQ-035 rst_i=1 SHALL immediately force IDLE, clear the frame register and counters, and drive all outputs to 0, including mid-run.
REQ-036 After rst_i deasserts, the block SHALL accept start_i on the first clock edge.

Verification (WIDTH=32, N_REG=24, BEAT_WIDTH=64, N_BEATS=12)
REQ-037 Word i = i+1, n_steps=1, ready=1, start at T -> 12 beats at T+1..T+12; beat0=0x00000002_00000001, beat11=0x00000018_00000017 with m_last_o=1; done_o at T+13.
REQ-038 n_steps=3, m_ready_i toggling 1,0 -> 36 transfers, m_step_o 0,1,2 with m_last_o on every 12th beat, data held during stalls, single done_o pulse.
REQ-039 regs_i all-ones written one cycle after start -> all beats match the start-cycle snapshot.
REQ-040 abort_i during beat 5 of step 0 -> m_valid_o=0 next cycle, no done_o; a new start then emits beat 0 of step 0.
REQ-041 start with n_steps=0 -> m_valid_o never asserted; done_o=1 at T+1 only.
REQ-042 rst_i asserted during beat 7 -> all outputs 0 without a clock edge; after release, start then emits beat0 of a new snapshot at T+1.
